// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_arbiter.
// A request transfers on a cycle where ReqValid[i] and ReqReady[i] are both high;
// valid may drop before ready without effect, and RspValid[i] is a one-cycle pulse.
interface alu_arbiter_if;
  logic [1:0] ReqValid;
  logic [1:0] ReqOp0;
  logic [1:0] ReqOp1;
  logic [7:0] ReqA0;
  logic [7:0] ReqA1;
  logic [7:0] ReqB0;
  logic [7:0] ReqB1;
  logic [1:0] ReqLock;
  logic [1:0] ReqReady;
  logic [1:0] RspValid;
  logic [7:0] RspData;

  modport master (
    output ReqValid, ReqOp0, ReqOp1, ReqA0, ReqA1, ReqB0, ReqB1, ReqLock,
    input  ReqReady, RspValid, RspData
  );

  modport slave (
    input  ReqValid, ReqOp0, ReqOp1, ReqA0, ReqA1, ReqB0, ReqB1, ReqLock,
    output ReqReady, RspValid, RspData
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin two-port sequencer for the shared picoMips ALU/accumulator,
// with per-requester lock chaining and a watchdog that breaks abandoned locks.
module alu_arbiter #(
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic       Clock,
  input  logic       nReset,
  alu_arbiter_if.slave req,
  output logic       AluWE,
  output logic       AluUseMul,
  output logic       AluUseA,
  output logic [7:0] AluDataA,
  output logic [7:0] AluDataB,
  input  logic [7:0] AluACC,
  output logic       Busy,
  output logic       Owner,
  output logic       LockBroken,
  output logic [1:0] DbgState
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RESP   = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  localparam logic [7:0] WD_LIMIT = 8'(LOCK_TIMEOUT);

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       lock_q, lock_d;
  logic       owner_q, owner_d;
  logic       ptr_q, ptr_d;
  logic [7:0] wd_q, wd_d;

  logic       grant_ok;
  logic       gnt;
  logic [1:0] ready;
  logic [1:0] rsp;
  logic       we;
  logic       broken;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      wd_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    lock_d   = lock_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    wd_d     = wd_q;
    grant_ok = 1'b0;
    gnt      = ptr_q;
    ready    = 2'b00;
    rsp      = 2'b00;
    we       = 1'b0;
    broken   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req.ReqValid) begin
          grant_ok = 1'b1;
          // On contention the pointer names the requester that did not win last.
          gnt = (&req.ReqValid) ? ptr_q : req.ReqValid[1];
        end
      end
      S_ISSUE: begin
        we      = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp[owner_q] = 1'b1;
        if (lock_q) begin
          state_d = S_LOCKED;
          wd_d    = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (req.ReqValid[owner_q]) begin
          grant_ok = 1'b1;
          gnt      = owner_q;
        end else if (wd_q + 8'd1 == WD_LIMIT) begin
          broken  = 1'b1;
          wd_d    = 8'd0;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (grant_ok) begin
      ready[gnt] = 1'b1;
      op_d       = gnt ? req.ReqOp1 : req.ReqOp0;
      a_d        = gnt ? req.ReqA1  : req.ReqA0;
      b_d        = gnt ? req.ReqB1  : req.ReqB0;
      lock_d     = req.ReqLock[gnt];
      owner_d    = gnt;
      ptr_d      = ~gnt;
      wd_d       = 8'd0;
      state_d    = S_ISSUE;
    end
  end

  // Opcode bit 0 selects operand A, bit 1 selects the multiplier path.
  assign AluUseA   = op_q[0];
  assign AluUseMul = op_q[1];
  assign AluDataA  = a_q;
  assign AluDataB  = b_q;
  assign AluWE     = we;

  assign req.ReqReady = ready;
  assign req.RspValid = rsp;
  assign req.RspData  = AluACC;

  assign Busy       = (state_q == S_ISSUE) || (state_q == S_RESP);
  assign Owner      = owner_q;
  assign LockBroken = broken;
  assign DbgState   = state_q;

endmodule
